// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: widths, register address type
// and the hardwired-zero register index.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register read port.
// Ports: addr, regs (x1..xN-1), byp_en/byp_addr/byp_data, data.
module regfile_read_port
  import riscv_pkg::*;
#(
  parameter int XLEN         = riscv_pkg::XLEN,
  parameter int NREGS        = riscv_pkg::NREGS,
  parameter bit WRITE_BYPASS = 1'b1
) (
  input  logic [REG_ADDR_W-1:0]        addr,
  input  logic [NREGS-1:1][XLEN-1:0]   regs,
  input  logic                         byp_en,
  input  logic [REG_ADDR_W-1:0]        byp_addr,
  input  logic [XLEN-1:0]              byp_data,
  output logic [XLEN-1:0]              data
);

  logic hit;

  // byp_en already excludes x0 and reset
  assign hit = WRITE_BYPASS && byp_en
               && (byp_addr == addr);

  always_comb begin
    data = '0;
    if (addr != REG_ZERO) begin
      if (hit) data = byp_data;
      else     data = regs[addr];
    end
  end

endmodule

// File: rtl/register_file.sv
// RV32I integer register file: 2 comb read ports, 1 sync write.
// Ports: clk, reset, rs1, rs2, rd, write_data, reg_write, read_data1/2.
module register_file
  import riscv_pkg::*;
#(
  parameter int XLEN         = riscv_pkg::XLEN,
  parameter int NREGS        = riscv_pkg::NREGS,
  parameter bit WRITE_BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]       write_data,
  input  logic                  reg_write,
  output logic [XLEN-1:0]       read_data1,
  output logic [XLEN-1:0]       read_data2
);

  logic [NREGS-1:1][XLEN-1:0] regs;
  logic                       wr_en;

  assign wr_en = reg_write && !reset
                 && (rd != REG_ZERO);

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else if (wr_en) begin
      regs[rd] <= write_data;
    end
  end

  regfile_read_port #(
    .XLEN(XLEN),
    .NREGS(NREGS),
    .WRITE_BYPASS(WRITE_BYPASS)
  ) u_port1 (
    .addr(rs1),
    .regs(regs),
    .byp_en(wr_en),
    .byp_addr(rd),
    .byp_data(write_data),
    .data(read_data1)
  );

  regfile_read_port #(
    .XLEN(XLEN),
    .NREGS(NREGS),
    .WRITE_BYPASS(WRITE_BYPASS)
  ) u_port2 (
    .addr(rs2),
    .regs(regs),
    .byp_en(wr_en),
    .byp_addr(rd),
    .byp_data(write_data),
    .data(read_data2)
  );

  always_comb begin
    if (rs1 == REG_ZERO) assert (read_data1 == '0);
    if (rs2 == REG_ZERO) assert (read_data2 == '0);
  end

  always @(posedge clk) begin
    if (reg_write === 1'b1) assert (!$isunknown(rd));
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed steps then
// random traffic against an array-based reference model.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] read_data1, read_data2;

  int tests;
  int fails;

  logic [31:0] model [32];

  register_file dut (
    .clk(clk),
    .reset(reset),
    .rs1(rs1),
    .rs2(rs2),
    .rd(rd),
    .write_data(write_data),
    .reg_write(reg_write),
    .read_data1(read_data1),
    .read_data2(read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural view: x0 is zero, a pending write is
  // visible on a matching port unless reset is high.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (reg_write && !reset && rd != 5'd0 && rd == a)
      return write_data;
    return model[a];
  endfunction

  task automatic check(input string tag);
    logic [31:0] e1, e2;
    e1 = exp_read(rs1);
    e2 = exp_read(rs2);
    tests++;
    assert (read_data1 === e1) else begin
      fails++;
      $error("FAIL %s port1 rs1=%0d got=%h exp=%h",
             tag, rs1, read_data1, e1);
    end
    tests++;
    assert (read_data2 === e2) else begin
      fails++;
      $error("FAIL %s port2 rs2=%0d got=%h exp=%h",
             tag, rs2, read_data2, e2);
    end
  endtask

  // Clock edge plus model update, returns at the next negedge
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (reg_write && rd != 5'd0) begin
      model[rd] = write_data;
    end
    @(negedge clk);
  endtask

  task automatic set_in(input logic rst, input logic we,
                        input logic [4:0] d, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2);
    reset      = rst;
    reg_write  = we;
    rd         = d;
    write_data = wd;
    rs1        = a1;
    rs2        = a2;
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;

    set_in(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    @(negedge clk);
    tick();
    reset = 1'b0;

    for (int a = 0; a < 32; a++) begin
      rs1 = 5'(a);
      rs2 = 5'(31 - a);
      #1;
      check("reset_clear");
    end

    @(negedge clk);
    set_in(1'b0, 1'b1, 5'd1, 32'd100, 5'd0, 5'd0);
    tick();
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd0);
    check("wr_x1");

    set_in(1'b0, 1'b1, 5'd2, 32'd200, 5'd1, 5'd0);
    tick();
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
    check("wr_x2");

    set_in(1'b0, 1'b1, 5'd0, 32'd300, 5'd0, 5'd0);
    check("x0_pre");
    tick();
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("x0_post");

    set_in(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    check("byp_pre");
    tick();
    check("byp_edge");
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    check("byp_post");

    set_in(1'b0, 1'b1, 5'd31, 32'hA5A5_0F0F, 5'd31, 5'd30);
    check("x31_pre");
    tick();
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd5);
    check("x31_post");

    set_in(1'b1, 1'b1, 5'd3, 32'h1234, 5'd3, 5'd1);
    check("rst_wr_pre");
    tick();
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd1);
    check("rst_wr_x3");
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 5'd2, 5'd5);
    check("rst_wr_x2");

    for (int n = 0; n < 400; n++) begin
      logic [4:0] a1;
      logic [4:0] a2;
      a1 = 5'($urandom_range(31));
      a2 = ($urandom_range(3) == 0) ? a1 : 5'($urandom_range(31));
      set_in(($urandom_range(49) == 0),
             ($urandom_range(3) != 0),
             ($urandom_range(3) == 0) ? a1 : 5'($urandom_range(31)),
             $urandom, a1, a2);
      check("rand_pre");
      tick();
      check("rand_post");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Integer register file for the RV32I core: 32 general-purpose 32-bit registers, two combinational read ports and one synchronous write port. It sits in the decode stage. Operands are read by `rs1`/`rs2` and results are written back from the writeback stage via `rd`. Register x0 is hardwired to zero.

## Interface
Parameters:
- `XLEN`, 32: register width in bits.
- `NREGS`, 32: number of architectural registers; must be a power of two.
- `WRITE_BYPASS`, 1: when 1, a write in progress is forwarded to a matching read port in the same cycle.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset; sampled on the rising edge of `clk`.
- `rs1`  input  5  read address, port 1.
- `rs2`  input  5  read address, port 2.
- `rd`  input  5  write address.
- `write_data`  input  XLEN  data to write.
- `reg_write`  input  1  write enable.
- `read_data1`  output  XLEN  contents of register `rs1`.
- `read_data2`  output  XLEN  contents of register `rs2`.

## Operation
- Storage: registers x1..x31, each XLEN bits. x0 has no storage and always reads as 0.
- Write:
  - On a rising edge with `reset`=0 and `reg_write`=1 and `rd`≠0, `regs[rd]` ← `write_data`.
  - A write to `rd`=0 is silently discarded.
- Read:
  - `read_data1` = 0 if `rs1`=0, else `regs[rs1]`. `read_data2` follows the same rule with `rs2`.
  - Reads are purely combinational and do not depend on the clock.
- Bypass (`WRITE_BYPASS`=1): if `reg_write`=1, `rd`≠0 and `rd`=`rsN`, then `read_data N` = `write_data` combinationally, before the edge.
  - With `WRITE_BYPASS`=0, the read returns the old value until the edge.
  - Bypass never applies to x0.
- Both read ports may address the same register, or the register being written, simultaneously. Each port resolves independently.
- Reset: on a rising edge with `reset`=1, all x1..x31 clear to 0.
  - Reset has priority over a simultaneous write; that write is lost.
  - Bypass is suppressed while `reset`=1, so reads return the stored and reset values.
- Reset value of outputs: after the reset edge, `read_data1` = `read_data2` = 0 for any address.
- Unknown or X on `rd` with `reg_write`=1 is a stimulus error. An assertion flags it in simulation.

## Timing
- Write latency: data presented at edge N is visible on the read ports, without bypass, immediately after edge N.
- Read latency: 0 cycles; output settles combinationally after a change of `rs1`/`rs2` or of the register contents.
- Reset latency: takes effect at the first rising edge with `reset`=1. Reset asserted mid-operation clears state at that edge, regardless of `reg_write`.
- No handshake; one write per cycle maximum.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN` = 32
  - `REG_ADDR_W` = 5
  - `NREGS` = 32
  - a `reg_addr_t` typedef (5-bit)
  - `REG_ZERO` = 5'd0
- One sub-module, `regfile_read_port`: takes an address, the storage array view and the bypass inputs, and produces one read result. It is instantiated twice.
- Storage is a flat array of NREGS-1 entries; index 0 is not implemented.
- Include assertions for the following:
  - x0 reads zero.
  - `rd` has no X when `reg_write`=1.

## Test plan
- Reset: hold `reset`=1 for 1 edge, then release. Read every address on both ports → all reads return 0.
- Write/read port 1: `rd`=1, `write_data`=100, `reg_write`=1 for one edge, then deassert. `rs1`=1 → `read_data1`=100.
- Write/read port 2: `rd`=2, `write_data`=200 for one edge. `rs2`=2 → `read_data2`=200, and `rs1`=1 still reads 100.
- x0 immutability: `rd`=0, `write_data`=300 for one edge. `rs1`=0 and `rs2`=0 → both read 0.
- Bypass and simultaneous access:
  - Setup: `rd`=5, `write_data`=0xDEADBEEF, `reg_write`=1, `rs1`=`rs2`=5.
  - Before the edge: both ports read 0xDEADBEEF (with `WRITE_BYPASS`=0, both read 0).
  - After the edge: both read 0xDEADBEEF.
- Reset during write: write 0x1234 to x3 with `reset`=1 on the same edge → x3 reads 0, and x1/x2 are cleared to 0.
